vram_rd_arbiter: RTL and testbench
==================================

VRAM_RD_ARBITER -- requirements
Module: vram_rd_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 8; consecutive requester-0 grants allowed while requester 1 waits.
REQ-002 Parameter: DATA_W, default 64; R-channel data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The port list SHALL be as follows.
- ACLK  in  1  system clock; all logic on rising edge.
- ARST  in  1  asynchronous active-high reset.
- S0_ARADDR  in  32  requester 0 (display) burst address.
- S0_ARVALID  in  1  requester 0 address valid.
- S0_ARREADY  out  1  requester 0 address accepted.
- S0_RDATA  out  DATA_W  read data to requester 0.
- S0_RVALID, S0_RLAST  out  1 each  routed beat valid / last beat.
- S0_RREADY  in  1  requester 0 accepts beat.
- S1_* (ARADDR, ARVALID, ARREADY, RDATA, RVALID, RLAST, RREADY): identical set for requester 1 (draw/capture).
- M_ARADDR  out  32  address to VRAM AXI port.
- M_ARVALID  out  1  address valid.
- M_ARREADY  in  1  slave accepts address.
- M_RDATA  in  DATA_W  read data.
- M_RVALID, M_RLAST  in  1 each  beat valid / last beat.
- M_RREADY  out  1  beat accepted.
- GRANT  out  1  current owner (0 or 1).
- BUSY  out  1  high in S_ADDR or S_DATA.

Function
REQ-005 The FSM SHALL have states S_IDLE, S_ADDR, S_DATA; exactly one burst is outstanding at a time.
REQ-006 In S_IDLE with no ARVALID asserted, the FSM SHALL stay in S_IDLE and drive M_ARVALID=0 and M_RREADY=0.
REQ-007 In S_IDLE with any ARVALID, GRANT SHALL be registered and the FSM SHALL enter S_ADDR next cycle. Requester 0 wins unless S1_ARVALID=1 and starve_cnt==STARVE_MAX, in which case requester 1 wins. A lone requester always wins.
REQ-008 M_ARADDR SHALL be registered from the winner's ARADDR on the S_IDLE->S_ADDR edge and held until the next grant.
REQ-009 In S_ADDR, M_ARVALID SHALL be 1. SN_ARREADY SHALL equal M_ARREADY for the granted requester and 0 for the other. On M_ARVALID&M_ARREADY the FSM SHALL enter S_DATA.
REQ-010 In S_DATA, the beat routing SHALL be:
- M_RREADY = granted requester's RREADY.
- Granted requester's RVALID = M_RVALID and RLAST = M_RLAST.
- Non-granted RVALID and RLAST = 0.
- M_RDATA SHALL be driven to both S0_RDATA and S1_RDATA.
REQ-011 On M_RVALID&M_RREADY&M_RLAST, the FSM SHALL return to S_IDLE. The next arbitration SHALL occur in that S_IDLE cycle, giving a minimum of 1 idle cycle between bursts.
REQ-012 starve_cnt (width clog2(STARVE_MAX+1)) SHALL be updated at each S_IDLE->S_ADDR edge:
- Requester 0 granted while S1_ARVALID=1: increment, saturating at STARVE_MAX.
- Requester 1 granted: clear to 0.
- Otherwise: hold.
REQ-013 M_RVALID outside S_DATA SHALL be ignored: not routed and not acknowledged.
REQ-014 A requester deasserting ARVALID after grant SHALL NOT abort the burst; the arbiter completes the address and data phases as latched.
REQ-015 Beats with M_RVALID=1 and M_RREADY=0 SHALL stall with no state change and no data loss; data stays combinational pass-through, not buffered.
REQ-016 GRANT SHALL be stable from the S_IDLE->S_ADDR edge until the cycle after RLAST acceptance.
REQ-017 SN_ARREADY SHALL be 0 for both requesters in S_IDLE and S_DATA.

Reset
REQ-018 ARST=1 SHALL asynchronously force the following: state S_IDLE, GRANT=0, M_ARADDR=0, starve_cnt=0, M_ARVALID=0, M_RREADY=0, all SN_ARREADY/RVALID/RLAST=0.
REQ-019 Reset asserted mid-burst SHALL abandon the burst; after deassertion, the first grant SHALL follow REQ-007 with starve_cnt=0.

Verification
REQ-020 Bench scenarios SHALL include:
- Only S0 requests 0x1000_0000, 32-beat burst with M_ARREADY one cycle late -> M_ARADDR=0x1000_0000, S0 sees 32 beats and RLAST, S1_RVALID stays 0, BUSY falls the cycle after RLAST.
- S0 and S1 continuously request, STARVE_MAX=8 -> grant sequence 0,0,0,0,0,0,0,0,1 repeating; starve_cnt=0 after each S1 grant.
- Only S1 requests -> every grant to S1, starve_cnt stays 0.
- S0 drops RREADY for 5 cycles mid-burst -> M_RREADY=0 for those 5 cycles, beat count stays 32, FSM stays in S_DATA.
- M_RVALID pulsed while in S_IDLE -> no SN_RVALID asserted, M_RREADY=0, state unchanged.
- ARST asserted during beat 10 of an S1 burst -> all outputs 0 the same cycle; after release with S0 and S1 both requesting, S0 is granted first.

Source files
------------

// File: rtl/vram_rd_arbiter.sv
// vram_rd_arbiter: two-requester AXI read-address/read-data arbiter in front
// of a single VRAM AXI read port. Requester 0 (display) has priority.
// Requester 1 (draw/capture) is guaranteed a grant after STARVE_MAX
// consecutive requester-0 grants taken while it was waiting. Only one burst
// is in flight at a time. The R channel is a combinational pass-through to
// the owner and is never buffered.
//
// Handshake semantics: every AR and R transfer happens on a rising ACLK edge
// where VALID and READY are both high. A VALID that sees READY low holds its
// payload unchanged. ARREADY toward a requester is high only while that
// requester owns the address phase. RVALID/RLAST toward a requester are high
// only while that requester owns the data phase.
module vram_rd_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned DATA_W     = 64,
  localparam int unsigned CNT_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic              ACLK,
  input  logic              ARST,
  // requester 0 (display)
  input  logic [31:0]       S0_ARADDR,
  input  logic              S0_ARVALID,
  output logic              S0_ARREADY,
  output logic [DATA_W-1:0] S0_RDATA,
  output logic              S0_RVALID,
  output logic              S0_RLAST,
  input  logic              S0_RREADY,
  // requester 1 (draw/capture)
  input  logic [31:0]       S1_ARADDR,
  input  logic              S1_ARVALID,
  output logic              S1_ARREADY,
  output logic [DATA_W-1:0] S1_RDATA,
  output logic              S1_RVALID,
  output logic              S1_RLAST,
  input  logic              S1_RREADY,
  // VRAM AXI read port
  output logic [31:0]       M_ARADDR,
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  input  logic [DATA_W-1:0] M_RDATA,
  input  logic              M_RVALID,
  input  logic              M_RLAST,
  output logic              M_RREADY,
  // status
  output logic              GRANT,
  output logic              BUSY,
  // debug: FSM state (0 idle, 1 addr, 2 data) and starvation counter
  output logic [1:0]        dbg_state_o,
  output logic [CNT_W-1:0]  dbg_starve_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic any_req;
  logic win1;
  logic rready_sel;

  // Requester 1 wins when it is alone, or when requester 0 has used up its
  // run of consecutive grants while requester 1 was waiting.
  assign any_req = S0_ARVALID | S1_ARVALID;
  assign win1    = S1_ARVALID & (~S0_ARVALID | (starve_q == STARVE_MAX_C));

  // Owner's RREADY; only forwarded to the slave during the data phase.
  assign rready_sel = grant_q ? S1_RREADY : S0_RREADY;

  // State, owner, latched address and starvation counter registers.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      araddr_q <= 32'h0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      araddr_q <= araddr_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic and channel routing for the current owner.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    araddr_d   = araddr_q;
    starve_d   = starve_q;
    M_ARVALID  = 1'b0;
    M_RREADY   = 1'b0;
    S0_ARREADY = 1'b0;
    S1_ARREADY = 1'b0;
    S0_RVALID  = 1'b0;
    S0_RLAST   = 1'b0;
    S1_RVALID  = 1'b0;
    S1_RLAST   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d  = S_ADDR;
          grant_d  = win1;
          araddr_d = win1 ? S1_ARADDR : S0_ARADDR;
          if (win1) begin
            starve_d = '0;
          end else if (S1_ARVALID && (starve_q != STARVE_MAX_C)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end

      S_ADDR: begin
        M_ARVALID = 1'b1;
        if (grant_q) begin
          S1_ARREADY = M_ARREADY;
        end else begin
          S0_ARREADY = M_ARREADY;
        end
        if (M_ARREADY) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        M_RREADY = rready_sel;
        if (grant_q) begin
          S1_RVALID = M_RVALID;
          S1_RLAST  = M_RLAST;
        end else begin
          S0_RVALID = M_RVALID;
          S0_RLAST  = M_RLAST;
        end
        if (M_RVALID && rready_sel && M_RLAST) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read data fans out to both requesters; RVALID alone marks the owner.
  assign S0_RDATA         = M_RDATA;
  assign S1_RDATA         = M_RDATA;
  assign M_ARADDR         = araddr_q;
  assign GRANT            = grant_q;
  assign BUSY             = (state_q != S_IDLE);
  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// Testbench for vram_rd_arbiter. Inputs are driven and outputs sampled on the
// falling edge of ACLK; the design acts on the rising edge.
module tb_vram_rd_arbiter;

  localparam int DATA_W = 64;

  logic              ACLK;
  logic              ARST;
  logic [31:0]       S0_ARADDR, S1_ARADDR, M_ARADDR;
  logic              S0_ARVALID, S0_ARREADY, S0_RVALID, S0_RLAST, S0_RREADY;
  logic              S1_ARVALID, S1_ARREADY, S1_RVALID, S1_RLAST, S1_RREADY;
  logic [DATA_W-1:0] S0_RDATA, S1_RDATA, M_RDATA;
  logic              M_ARVALID, M_ARREADY, M_RVALID, M_RLAST, M_RREADY;
  logic              GRANT, BUSY;
  logic [1:0]        dbg_state_o;
  logic [3:0]        dbg_starve_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];

  vram_rd_arbiter #(.STARVE_MAX(8), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST), .S1_RREADY(S1_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RLAST(M_RLAST), .M_RREADY(M_RREADY),
    .GRANT(GRANT), .BUSY(BUSY),
    .dbg_state_o(dbg_state_o), .dbg_starve_cnt_o(dbg_starve_cnt_o)
  );

  // ---------------- clock ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},    64'(BUSY), 64'd0);
    chk({nm, "_grant"},   64'(GRANT), 64'd0);
    chk({nm, "_araddr"},  64'(M_ARADDR), 64'd0);
    chk({nm, "_arvalid"}, 64'(M_ARVALID), 64'd0);
    chk({nm, "_rready"},  64'(M_RREADY), 64'd0);
    chk({nm, "_arready"}, 64'({S0_ARREADY, S1_ARREADY}), 64'd0);
    chk({nm, "_rvalid"},  64'({S0_RVALID, S1_RVALID}), 64'd0);
    chk({nm, "_rlast"},   64'({S0_RLAST, S1_RLAST}), 64'd0);
    chk({nm, "_state"},   64'(dbg_state_o), 64'd0);
    chk({nm, "_cnt"},     64'(dbg_starve_cnt_o), 64'd0);
  endtask

  // One complete arbitration + burst. Entered and left on a falling edge
  // with the FSM in idle. rst_at >= 0 pulses ARST when that beat is offered.
  task automatic do_burst(input logic r0, input logic r1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic exp_g, input logic [3:0] exp_cnt,
                          input int beats, input int ar_delay,
                          input int stall_at, input int rst_at);
    int n;
    int sink_cnt;
    int stall_left;
    int other_seen;
    bit stalling;
    logic g_rvalid, g_rlast, o_rvalid, o_rlast;
    logic [DATA_W-1:0] g_rdata, o_rdata, exp_d;

    S0_ARVALID = r0; S1_ARVALID = r1;
    S0_ARADDR  = a0; S1_ARADDR  = a1;
    M_ARREADY  = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0;
    S0_RREADY  = 1'b1; S1_RREADY = 1'b1;
    #1;
    chk("idle_busy",    64'(BUSY), 64'd0);
    chk("idle_arvalid", 64'(M_ARVALID), 64'd0);
    chk("idle_arready", 64'({S0_ARREADY, S1_ARREADY}), 64'd0);

    // address phase
    @(negedge ACLK);
    S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;   // dropping ARVALID must not abort
    #1;
    chk("addr_state",   64'(dbg_state_o), 64'd1);
    chk("addr_grant",   64'(GRANT), 64'(exp_g));
    chk("addr_araddr",  64'(M_ARADDR), 64'(exp_g ? a1 : a0));
    chk("addr_cnt",     64'(dbg_starve_cnt_o), 64'(exp_cnt));
    chk("addr_arvalid", 64'(M_ARVALID), 64'd1);
    chk("addr_busy",    64'(BUSY), 64'd1);
    for (int i = 0; i < ar_delay; i++) begin
      chk("addr_wait_arready", 64'({S0_ARREADY, S1_ARREADY}), 64'd0);
      @(negedge ACLK);
      #1;
      chk("addr_wait_state", 64'(dbg_state_o), 64'd1);
    end
    M_ARREADY = 1'b1;
    #1;
    chk("addr_arready", 64'({S1_ARREADY, S0_ARREADY}), exp_g ? 64'd2 : 64'd1);
    @(negedge ACLK);
    M_ARREADY = 1'b0;
    #1;
    chk("data_state",   64'(dbg_state_o), 64'd2);
    chk("data_arvalid", 64'(M_ARVALID), 64'd0);

    // data phase
    n = 0; sink_cnt = 0; other_seen = 0;
    stall_left = (stall_at >= 0) ? 5 : 0;
    exp_q.delete();
    M_RDATA = {$urandom, $urandom};
    exp_q.push_back(M_RDATA);
    for (int cyc = 0; cyc < 200 && n < beats; cyc++) begin
      stalling = (n == stall_at) && (stall_left > 0);
      M_RVALID = 1'b1;
      M_RLAST  = (n == beats - 1);
      if (exp_g) begin S1_RREADY = !stalling; S0_RREADY = 1'($urandom_range(0, 1)); end
      else       begin S0_RREADY = !stalling; S1_RREADY = 1'($urandom_range(0, 1)); end
      if (n == rst_at) begin
        ARST = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge ACLK);
        ARST = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0;
        exp_q.delete();
        return;
      end
      #1;
      g_rvalid = exp_g ? S1_RVALID : S0_RVALID;
      g_rlast  = exp_g ? S1_RLAST  : S0_RLAST;
      g_rdata  = exp_g ? S1_RDATA  : S0_RDATA;
      o_rvalid = exp_g ? S0_RVALID : S1_RVALID;
      o_rlast  = exp_g ? S0_RLAST  : S1_RLAST;
      o_rdata  = exp_g ? S0_RDATA  : S1_RDATA;
      if (o_rvalid || o_rlast) other_seen++;
      chk("beat_rvalid", 64'(g_rvalid), 64'd1);
      chk("beat_rlast",  64'(g_rlast), 64'(n == beats - 1));
      chk("beat_rready", 64'(M_RREADY), 64'(!stalling));
      if (g_rvalid && M_RREADY) begin
        exp_d = exp_q.pop_front();
        chk("beat_rdata",       g_rdata, exp_d);
        chk("beat_rdata_other", o_rdata, exp_d);
        sink_cnt++;
      end
      @(negedge ACLK);
      if (stalling) begin
        stall_left--;
        #1;
        chk("stall_state", 64'(dbg_state_o), 64'd2);
      end else begin
        n++;
        if (n < beats) begin
          M_RDATA = {$urandom, $urandom};
          exp_q.push_back(M_RDATA);
        end
      end
    end
    M_RVALID = 1'b0; M_RLAST = 1'b0;
    #1;
    chk("sink_beats",   64'(sink_cnt), 64'(beats));
    chk("other_rvalid", 64'(other_seen), 64'd0);
    chk("end_busy",     64'(BUSY), 64'd0);
    chk("end_state",    64'(dbg_state_o), 64'd0);
    chk("end_grant",    64'(GRANT), 64'(exp_g));
  endtask

  // ---------------- table of arbitration vectors ----------------
  typedef struct {
    logic       r0;
    logic       r1;
    logic       exp_g;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // both requesting: eight requester-0 grants, then requester 1
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 4'(i + 1)};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd0};   // lone S1
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd0};   // lone S0: counter holds
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd1};

    // reset block
    ARST = 1'b1;
    S0_ARADDR = '0; S1_ARADDR = '0; S0_ARVALID = 0; S1_ARVALID = 0;
    S0_RREADY = 0; S1_RREADY = 0; M_ARREADY = 0; M_RDATA = '0;
    M_RVALID = 0; M_RLAST = 0;
    repeat (2) @(negedge ACLK);
    #1;
    chk_all_zero("reset");
    @(negedge ACLK);
    ARST = 1'b0;

    // lone S0, 32 beats, ARREADY one cycle late
    do_burst(1, 0, 32'h1000_0000, 32'h2222_0000, 0, 4'd0, 32, 1, -1, -1);

    // S0 drops RREADY for 5 cycles at beat 10
    do_burst(1, 0, 32'h1000_4000, 32'h2222_0000, 0, 4'd0, 32, 0, 10, -1);

    // M_RVALID pulse while idle must be ignored
    S0_ARVALID = 0; S1_ARVALID = 0; M_RVALID = 1; M_RLAST = 1;
    #1;
    chk("idle_pulse_rvalid", 64'({S0_RVALID, S1_RVALID}), 64'd0);
    chk("idle_pulse_rready", 64'(M_RREADY), 64'd0);
    @(negedge ACLK);
    #1;
    chk("idle_pulse_state", 64'(dbg_state_o), 64'd0);
    chk("idle_pulse_busy",  64'(BUSY), 64'd0);
    M_RVALID = 0; M_RLAST = 0;

    // table-driven arbitration sequence
    for (int i = 0; i < 14; i++) begin
      do_burst(vecs[i].r0, vecs[i].r1, 32'h0A00_0000 + 32'(i * 16'h100),
               32'h0B00_0000 + 32'(i * 16'h100), vecs[i].exp_g, vecs[i].exp_cnt,
               2, i % 3, -1, -1);
    end

    // reset during beat 10 of an S1 burst, then both request: S0 first
    do_burst(0, 1, 32'h3000_0000, 32'h4000_0000, 1, 4'd0, 32, 0, -1, 10);
    do_burst(1, 1, 32'h5000_0000, 32'h6000_0000, 0, 4'd1, 4, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
